// File: rtl/mul255_add.sv
// mul255_add: rebuilds a dividend from a divide-by-255 quotient and remainder,
// y = q*255 + r, using one shift-add per set bit of the constant 255.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous, active-high reset
//   q        quotient operand (WIDTH bits), sampled on the accepting edge only
//   r        remainder operand (8 bits), sampled on the accepting edge only
//   start    request, accepted only while idle
//   busy     high while the shift-add iteration is running
//   done     one-cycle pulse; y, ovf and rem_err are valid
//   y        low WIDTH bits of q*255+r, held until the next result is written
//   ovf      result did not fit in WIDTH bits
//   rem_err  r was 8'hFF, which is not a legal remainder
//
// Handshake: start is honoured only on an edge where the block is idle; any
// start seen while running or while done is high is ignored. done pulses for
// exactly one cycle, with busy low in that cycle.
//
// Build option MUL255_FAST_EN: two additions per clock (four run cycles
// instead of eight). Results and flags are identical in both builds.

module mul255_add #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q,
    input  logic [7:0]       r,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             ovf,
    output logic             rem_err
);

    localparam int AW = WIDTH + 8;

`ifdef MUL255_FAST_EN
    localparam logic [2:0] LAST_CNT = 3'd3;
`else
    localparam logic [2:0] LAST_CNT = 3'd7;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [AW-1:0]   acc;
    logic [AW-1:0]   sreg;
    logic [AW-1:0]   acc_next;
    logic [AW-1:0]   sreg_next;
    logic [2:0]      cnt;
    logic [7:0]      r_lat;
    logic            accept;
    logic            last_step;

    assign accept    = (state == IDLE) && start;
    assign last_step = (state == RUN) && (cnt == LAST_CNT);

    // One iteration of the shift-add. sreg holds q shifted to the weight of
    // the current bit(s) of 255; every bit of 255 is set, so every step adds.
    always_comb begin
        acc_next  = acc;
        sreg_next = sreg;
`ifdef MUL255_FAST_EN
        acc_next  = acc + sreg + (sreg << 1);
        sreg_next = sreg << 2;
`else
        acc_next  = acc + sreg;
        sreg_next = sreg << 1;
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (cnt == LAST_CNT) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:  busy = 1'b1;
            DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: the accumulator starts at r so the final add lands on
    // q*255 + r without a separate correction step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            sreg    <= '0;
            cnt     <= 3'd0;
            r_lat   <= 8'd0;
            y       <= '0;
            ovf     <= 1'b0;
            rem_err <= 1'b0;
        end else if (accept) begin
            acc   <= {{(AW-8){1'b0}}, r};
            sreg  <= {8'd0, q};
            cnt   <= 3'd0;
            r_lat <= r;
        end else if (state == RUN) begin
            acc  <= acc_next;
            sreg <= sreg_next;
            cnt  <= cnt + 3'd1;
            if (last_step) begin
                y       <= acc_next[WIDTH-1:0];
                ovf     <= |acc_next[AW-1:WIDTH];
                rem_err <= (r_lat == 8'hFF);
            end
        end
    end

endmodule

// File: tb/tb_mul255_add.sv
// Self-checking bench for mul255_add: directed cases plus randomized operands,
// compared against an arithmetic reference (q*255 + r in 64-bit math).

module tb_mul255_add;

    localparam int WIDTH = 32;
`ifdef MUL255_FAST_EN
    localparam int RUN_EDGES = 4;
`else
    localparam int RUN_EDGES = 8;
`endif
    localparam int PERIOD = RUN_EDGES + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] q;
    logic [7:0]       r;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             ovf;
    logic             rem_err;

    int total = 0;
    int bad   = 0;

    // expected {ovf, rem_err, y}
    logic [WIDTH+1:0] exp_q[$];

    mul255_add #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .q       (q),
        .r       (r),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .y       (y),
        .ovf     (ovf),
        .rem_err (rem_err)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on the specification's formula.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] qq, input logic [7:0] rr);
        logic [63:0] full;
        full = 64'(qq) * 64'd255 + 64'(rr);
        return {(full[63:WIDTH] != 0), (rr == 8'hFF), full[WIDTH-1:0]};
    endfunction

    // Driver: starts one operation at a negedge while idle, follows it to the
    // done pulse and back to idle. poke pulses start while running and in DONE.
    task automatic run_op(input logic [WIDTH-1:0] qq, input logic [7:0] rr, input bit poke);
        logic [WIDTH+1:0] e;
        e = '0;
        q = qq;
        r = rr;
        start = 1'b1;
        exp_q.push_back(model(qq, rr));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        q = $urandom;
        r = 8'($urandom);
        check_val("busy_after_accept", 64'(busy), 64'd1);
        check_val("done_after_accept", 64'(done), 64'd0);
        for (int i = 1; i <= RUN_EDGES; i++) begin
            if (poke && i == 2) start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (i < RUN_EDGES) begin
                check_val("busy_run", 64'(busy), 64'd1);
                check_val("done_run", 64'(done), 64'd0);
            end else begin
                check_val("done_pulse", 64'(done), 64'd1);
                check_val("busy_in_done", 64'(busy), 64'd0);
                if (exp_q.size() == 0) begin
                    check_val("scoreboard_empty", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("y", 64'(y), 64'(e[WIDTH-1:0]));
                    check_val("ovf", 64'(ovf), 64'(e[WIDTH+1]));
                    check_val("rem_err", 64'(rem_err), 64'(e[WIDTH]));
                end
                if (poke) start = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_val("done_one_cycle", 64'(done), 64'd0);
        check_val("busy_idle", 64'(busy), 64'd0);
        check_val("y_held", 64'(y), 64'(e[WIDTH-1:0]));
    endtask

    initial begin
        logic [WIDTH+1:0] e;
        int ndone;

        rst = 1'b1;
        start = 1'b0;
        q = '0;
        r = '0;
        repeat (2) @(negedge clk);
        check_val("rst_y", 64'(y), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_flags", 64'({ovf, rem_err}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_busy", 64'(busy), 64'd0);

        // directed cases
        run_op(32'd13, 8'd0, 1'b0);
        check_val("y_13", 64'(y), 64'd3315);
        run_op(32'd97, 8'd25, 1'b0);
        check_val("y_97", 64'(y), 64'd24760);
        run_op(32'd2, 8'd3, 1'b0);
        check_val("y_2", 64'(y), 64'd513);
        run_op(32'hFFFF_FFFF, 8'd0, 1'b0);
        check_val("y_max", 64'(y), 64'hFFFF_FF01);
        check_val("ovf_max", 64'(ovf), 64'd1);
        run_op(32'd186741, 8'd255, 1'b1);
        check_val("y_remerr", 64'(y), 64'd47619210);
        check_val("remerr_set", 64'(rem_err), 64'd1);

        // outputs hold while idle
        repeat (5) @(negedge clk);
        check_val("hold_y", 64'(y), 64'd47619210);
        check_val("hold_flags", 64'({ovf, rem_err}), 64'b01);
        check_val("hold_done", 64'(done), 64'd0);

        // reset during the 4th run cycle
        q = 32'd1000;
        r = 8'd9;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_done", 64'(done), 64'd0);
        check_val("midrst_y", 64'(y), 64'd0);
        check_val("midrst_flags", 64'({ovf, rem_err}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < RUN_EDGES + 2; i++) begin
            @(negedge clk);
            check_val("midrst_no_done", 64'(done), 64'd0);
        end
        run_op(32'd1, 8'd1, 1'b0);
        check_val("y_after_rst", 64'(y), 64'd256);

        // start held high: one accept per idle edge
        ndone = 0;
        e = model(32'd5, 8'd7);
        q = 32'd5;
        r = 8'd7;
        start = 1'b1;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                ndone++;
                check_val("held_start_y", 64'(y), 64'(e[WIDTH-1:0]));
            end
        end
        start = 1'b0;
        check_val("held_start_count", 64'(ndone), 64'd3);
        @(negedge clk);

        // randomized operands
        for (int n = 0; n < 30; n++) begin
            logic [WIDTH-1:0] rq;
            logic [7:0] rr;
            rq = (n % 3 == 0) ? WIDTH'($urandom_range(0, 1000)) : WIDTH'($urandom);
            rr = (n % 5 == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            run_op(rq, rr, ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        check_val("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
